// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetches and load/stores
// onto a single 8-bit RAM port, one byte per cycle, with load sign-extension.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [31:0]       if_rdata_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic              mem_signed_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i,
  output logic              dbg_busy_o,
  output logic [2:0]        dbg_cnt_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state_q;
  logic [2:0]        cnt_q, n_q;
  logic              owner_mem_q, store_q, signed_q, fair_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q, rbuf_q;
  logic              ram_we_q, if_done_q, mem_done_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_wdata_q;
  logic [31:0]       if_rdata_q, mem_rdata_q;

  logic              can_accept, grant_if, grant_mem, last_byte, flush_abort;
  logic [2:0]        cnt_nx, req_len;
  logic [ADDR_W-1:0] next_addr;
  logic [7:0]        next_wbyte;
  logic [31:0]       asm_word, ld_word;

  always_comb begin
    can_accept  = (state_q == IDLE) && !(if_done_q || mem_done_q);
    // A pending fetch wins only when the previous grant went to MEM while it waited.
    grant_if    = can_accept && if_req_i && !if_flush_i && (!mem_req_i || fair_q);
    grant_mem   = can_accept && mem_req_i && !grant_if;
    last_byte   = (cnt_q == (n_q - 3'd1));
    flush_abort = (state_q == BUSY) && !owner_mem_q && if_flush_i;
    cnt_nx      = cnt_q + 3'd1;
    next_addr   = base_q + ADDR_W'(cnt_nx);

    case (mem_len_i)
      2'b00:   req_len = 3'd1;
      2'b01:   req_len = 3'd2;
      default: req_len = 3'd4;
    endcase

    case (cnt_nx[1:0])
      2'd0:    next_wbyte = wdata_q[7:0];
      2'd1:    next_wbyte = wdata_q[15:8];
      2'd2:    next_wbyte = wdata_q[23:16];
      default: next_wbyte = wdata_q[31:24];
    endcase

    // Result so far with this cycle's RAM byte merged into its slot.
    asm_word = rbuf_q;
    case (cnt_q[1:0])
      2'd0:    asm_word[7:0]   = ram_rdata_i;
      2'd1:    asm_word[15:8]  = ram_rdata_i;
      2'd2:    asm_word[23:16] = ram_rdata_i;
      default: asm_word[31:24] = ram_rdata_i;
    endcase

    case (n_q)
      3'd1:    ld_word = {{24{signed_q & asm_word[7]}}, asm_word[7:0]};
      3'd2:    ld_word = {{16{signed_q & asm_word[15]}}, asm_word[15:0]};
      default: ld_word = asm_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      owner_mem_q <= 1'b0;
      store_q     <= 1'b0;
      signed_q    <= 1'b0;
      fair_q      <= 1'b0;
      base_q      <= '0;
      wdata_q     <= 32'd0;
      rbuf_q      <= 32'd0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 8'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_if || grant_mem) begin
            state_q     <= BUSY;
            cnt_q       <= 3'd0;
            owner_mem_q <= grant_mem;
            store_q     <= grant_mem && mem_we_i;
            signed_q    <= mem_signed_i;
            n_q         <= grant_mem ? req_len : 3'd4;
            base_q      <= grant_mem ? mem_addr_i : if_addr_i;
            wdata_q     <= mem_wdata_i;
            rbuf_q      <= 32'd0;
            ram_addr_q  <= grant_mem ? mem_addr_i : if_addr_i;
            ram_we_q    <= grant_mem && mem_we_i;
            ram_wdata_q <= grant_mem ? mem_wdata_i[7:0] : 8'd0;
            fair_q      <= grant_mem ? (fair_q | if_req_i) : 1'b0;
          end
        end
        BUSY: begin
          if (flush_abort) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            ram_we_q <= 1'b0;
          end else if (last_byte) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            ram_we_q <= 1'b0;
            if (owner_mem_q) begin
              mem_done_q <= 1'b1;
              if (!store_q) mem_rdata_q <= ld_word;
            end else begin
              if_done_q  <= 1'b1;
              if_rdata_q <= asm_word;
            end
          end else begin
            cnt_q      <= cnt_nx;
            ram_addr_q <= next_addr;
            rbuf_q     <= asm_word;
            if (store_q) ram_wdata_q <= next_wbyte;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign if_done_o   = if_done_q;
  assign mem_done_o  = mem_done_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign dbg_busy_o  = (state_q == BUSY);
  assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: fetch, signed/unsigned loads, store, arbitration,
// flush, mid-transaction reset and address wrap, against a 256-byte RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, if_flush_i, mem_req_i, mem_we_i, mem_signed_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i;
  logic [1:0]  mem_len_i;
  logic [31:0] if_rdata_o, mem_rdata_o, ram_addr_o;
  logic        if_done_o, mem_done_o, ram_we_o, dbg_busy_o;
  logic [7:0]  ram_wdata_o, ram_rdata_i;
  logic [2:0]  dbg_cnt_o;

  logic [7:0]  ram_m [0:255];
  int          checks = 0;
  int          errors = 0;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_rdata_o(if_rdata_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
    .mem_signed_i(mem_signed_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i), .dbg_busy_o(dbg_busy_o), .dbg_cnt_o(dbg_cnt_o)
  );

  // Clock / RAM model: combinational read, write on the rising edge.
  always #5 clk = ~clk;
  always_comb ram_rdata_i = ram_m[ram_addr_o[7:0]];
  always @(posedge clk) if (ram_we_o) ram_m[ram_addr_o[7:0]] <= ram_wdata_o;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mem_op(input logic we, input logic [1:0] len, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd);
    mem_we_i = we; mem_len_i = len; mem_signed_i = sgn;
    mem_addr_i = addr; mem_wdata_i = wd; mem_req_i = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram_m[i] = 8'h00;
    rst = 1'b1; if_req_i = 0; if_flush_i = 0; if_addr_i = 0;
    mem_req_i = 0; mem_we_i = 0; mem_len_i = 0; mem_signed_i = 0;
    mem_addr_i = 0; mem_wdata_i = 0;

    // Reset state
    tick(); tick();
    chk("rst_we", {31'd0, ram_we_o}, 32'd0);
    chk("rst_addr", ram_addr_o, 32'd0);
    chk("rst_wdata", {24'd0, ram_wdata_o}, 32'd0);
    chk("rst_dones", {30'd0, if_done_o, mem_done_o}, 32'd0);
    chk("rst_rdata", if_rdata_o | mem_rdata_o, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_dones", {30'd0, if_done_o, mem_done_o}, 32'd0);

    // Fetch at 0x100
    ram_m[8'h00] = 8'h13; ram_m[8'h01] = 8'h00; ram_m[8'h02] = 8'h00; ram_m[8'h03] = 8'h00;
    if_addr_i = 32'h100; if_req_i = 1'b1;
    tick();
    chk("fetch_a0", ram_addr_o, 32'h100);
    chk("fetch_we", {31'd0, ram_we_o}, 32'd0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("fetch_addr", ram_addr_o, 32'h100 + k);
      chk("fetch_nodone", {31'd0, if_done_o}, 32'd0);
    end
    tick();
    chk("fetch_done", {31'd0, if_done_o}, 32'd1);
    chk("fetch_data", if_rdata_o, 32'h0000_0013);
    if_req_i = 1'b0;
    tick();
    chk("fetch_done_pulse", {31'd0, if_done_o}, 32'd0);
    chk("fetch_data_hold", if_rdata_o, 32'h0000_0013);

    // Signed byte load, unsigned half, signed half
    ram_m[8'h20] = 8'h80; ram_m[8'h21] = 8'h01;
    mem_op(1'b0, 2'b00, 1'b1, 32'h20, 32'd0);
    tick();
    chk("lb_addr", ram_addr_o, 32'h20);
    tick();
    chk("lb_done", {31'd0, mem_done_o}, 32'd1);
    chk("lb_data", mem_rdata_o, 32'hFFFF_FF80);
    mem_req_i = 1'b0;
    tick();
    mem_op(1'b0, 2'b01, 1'b0, 32'h20, 32'd0);
    tick(); tick();
    chk("lhu_early", {31'd0, mem_done_o}, 32'd0);
    tick();
    chk("lhu_done", {31'd0, mem_done_o}, 32'd1);
    chk("lhu_data", mem_rdata_o, 32'h0000_0180);
    mem_req_i = 1'b0;
    tick();
    ram_m[8'h21] = 8'h91;
    mem_op(1'b0, 2'b01, 1'b1, 32'h20, 32'd0);
    tick(); tick(); tick();
    chk("lh_data", mem_rdata_o, 32'hFFFF_9180);
    mem_req_i = 1'b0;
    tick();

    // Store word
    mem_op(1'b1, 2'b10, 1'b0, 32'h40, 32'hAABB_CCDD);
    tick();
    chk("sw_we0", {31'd0, ram_we_o}, 32'd1);
    chk("sw_a0", ram_addr_o, 32'h40);
    chk("sw_d0", {24'd0, ram_wdata_o}, 32'hDD);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("sw_we", {31'd0, ram_we_o}, 32'd1);
      chk("sw_addr", ram_addr_o, 32'h40 + k);
      chk("sw_byte", {24'd0, ram_wdata_o}, (32'hAABB_CCDD >> (8 * k)) & 32'hFF);
    end
    tick();
    chk("sw_we_off", {31'd0, ram_we_o}, 32'd0);
    chk("sw_done", {31'd0, mem_done_o}, 32'd1);
    mem_req_i = 1'b0;
    chk("sw_ram", {ram_m[8'h43], ram_m[8'h42], ram_m[8'h41], ram_m[8'h40]}, 32'hAABB_CCDD);
    tick();

    // Contention: MEM first, then IF, then MEM again
    ram_m[8'h20] = 8'h80; ram_m[8'h21] = 8'h01; ram_m[8'h22] = 8'h02; ram_m[8'h23] = 8'h03;
    if_addr_i = 32'h100; if_req_i = 1'b1;
    mem_op(1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
    tick();
    chk("arb_mem_first", ram_addr_o, 32'h20);
    tick(); tick(); tick(); tick();
    chk("arb_mem_done", {31'd0, mem_done_o}, 32'd1);
    chk("arb_mem_data", mem_rdata_o, 32'h0302_0180);
    tick();
    chk("arb_gap", {31'd0, dbg_busy_o}, 32'd0);
    tick();
    chk("arb_if_second", ram_addr_o, 32'h100);
    chk("arb_if_busy", {31'd0, dbg_busy_o}, 32'd1);
    tick(); tick(); tick(); tick();
    chk("arb_if_done", {31'd0, if_done_o}, 32'd1);
    chk("arb_if_data", if_rdata_o, 32'h0000_0013);
    if_req_i = 1'b0;
    tick();
    chk("arb_gap2", {31'd0, dbg_busy_o}, 32'd0);
    tick();
    chk("arb_mem_again", ram_addr_o, 32'h20);
    chk("arb_mem_again_busy", {31'd0, dbg_busy_o}, 32'd1);
    tick(); tick(); tick(); tick();
    chk("arb_mem2_done", {31'd0, mem_done_o}, 32'd1);
    mem_req_i = 1'b0;
    tick();

    // Flush at cnt = 2
    ram_m[8'h00] = 8'h55;
    if_req_i = 1'b1;
    tick(); tick(); tick();
    chk("flush_cnt", {29'd0, dbg_cnt_o}, 32'd2);
    if_flush_i = 1'b1; if_req_i = 1'b0;
    tick();
    chk("flush_idle", {31'd0, dbg_busy_o}, 32'd0);
    chk("flush_nodone", {31'd0, if_done_o}, 32'd0);
    chk("flush_we", {31'd0, ram_we_o}, 32'd0);
    if_req_i = 1'b1;
    tick();
    chk("flush_no_grant", {31'd0, dbg_busy_o}, 32'd0);
    chk("flush_data_hold", if_rdata_o, 32'h0000_0013);
    if_req_i = 1'b0;
    mem_op(1'b0, 2'b00, 1'b0, 32'h20, 32'd0);
    tick(); tick();
    chk("flush_mem_done", {31'd0, mem_done_o}, 32'd1);
    chk("flush_mem_data", mem_rdata_o, 32'h0000_0080);
    mem_req_i = 1'b0; if_flush_i = 1'b0;
    tick();

    // Reset at cnt = 1 of a store
    mem_op(1'b1, 2'b10, 1'b0, 32'h60, 32'h1122_3344);
    tick(); tick();
    chk("rst_mid_cnt", {29'd0, dbg_cnt_o}, 32'd1);
    chk("rst_mid_we", {31'd0, ram_we_o}, 32'd1);
    rst = 1'b1; mem_req_i = 1'b0;
    tick();
    chk("rst_mid_we_off", {31'd0, ram_we_o}, 32'd0);
    chk("rst_mid_addr", ram_addr_o, 32'd0);
    chk("rst_mid_wdata", {24'd0, ram_wdata_o}, 32'd0);
    chk("rst_mid_rdata", if_rdata_o | mem_rdata_o, 32'd0);
    chk("rst_mid_idle", {31'd0, dbg_busy_o}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_mid_dones", {30'd0, if_done_o, mem_done_o}, 32'd0);

    // Wrap-around word load
    ram_m[8'hFE] = 8'h11; ram_m[8'hFF] = 8'h22; ram_m[8'h00] = 8'h33; ram_m[8'h01] = 8'h44;
    mem_op(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'd0);
    tick();
    chk("wrap_a0", ram_addr_o, 32'hFFFF_FFFE);
    tick();
    chk("wrap_a1", ram_addr_o, 32'hFFFF_FFFF);
    tick();
    chk("wrap_a2", ram_addr_o, 32'h0000_0000);
    tick();
    chk("wrap_a3", ram_addr_o, 32'h0000_0001);
    tick();
    chk("wrap_done", {31'd0, mem_done_o}, 32'd1);
    chk("wrap_data", mem_rdata_o, 32'h4433_2211);
    mem_req_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of all byte addresses.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port if_req_i, input, 1: instruction-fetch request, held until if_done_o.
REQ-005 SHALL have port if_addr_i, input, ADDR_W: fetch base address.
REQ-006 SHALL have port if_flush_i, input, 1: abort any pending or in-flight fetch.
REQ-007 SHALL have port if_rdata_o, output, 32: fetched word, little-endian.
REQ-008 SHALL have port if_done_o, output, 1: one-cycle completion pulse for a fetch.
REQ-009 SHALL have port mem_req_i, input, 1: load/store request, held until mem_done_o.
REQ-010 SHALL have port mem_we_i, input, 1: 1 = store, 0 = load.
REQ-011 SHALL have port mem_len_i, input, 2: 00 = byte, 01 = half, 10/11 = word.
REQ-012 SHALL have port mem_signed_i, input, 1: sign-extend load result.
REQ-013 SHALL have port mem_addr_i, input, ADDR_W: load/store base address.
REQ-014 SHALL have port mem_wdata_i, input, 32: store data; byte k goes to base+k.
REQ-015 SHALL have port mem_rdata_o, output, 32: extended load result.
REQ-016 SHALL have port mem_done_o, output, 1: one-cycle completion pulse for a load/store.
REQ-017 SHALL have port ram_we_o, output, 1: RAM byte write enable.
REQ-018 SHALL have port ram_addr_o, output, ADDR_W: RAM byte address.
REQ-019 SHALL have port ram_wdata_o, output, 8: RAM write byte.
REQ-020 SHALL have port ram_rdata_i, input, 8: RAM read byte, valid the cycle after its address is driven.

Function
REQ-021 SHALL implement states IDLE and BUSY, with a byte counter cnt[2:0], latched owner, op, length N (1/2/4), base address and write data.
REQ-022 SHALL drive all outputs from registers.
REQ-023 In IDLE with any done output high, SHALL accept no request that cycle.
REQ-024 In IDLE, SHALL grant mem_req_i over if_req_i, except when the fair flag is set and if_req_i is high, in which case the fetch wins.
REQ-025 SHALL set the fair flag when a MEM grant occurs while if_req_i is high, and clear it on any IF grant.
REQ-026 At acceptance edge E0, SHALL latch the request, drive ram_addr_o = base, set ram_we_o = (store), set ram_wdata_o = wdata[7:0], set cnt = 0 and enter BUSY.
REQ-027 For loads/fetches at edge E_k (k = 1..N), SHALL capture ram_rdata_i as result byte k-1.
REQ-028 For loads/fetches at edge E_k with k < N, SHALL drive ram_addr_o = base + k.
REQ-029 For stores at edge E_k (k = 1..N-1), SHALL drive ram_addr_o = base + k and ram_wdata_o = wdata byte k, keeping ram_we_o = 1.
REQ-030 At edge E_N, SHALL set ram_we_o = 0, pulse the owner's done for exactly one cycle and return to IDLE; latency is N cycles from E0 to done visible.
REQ-031 SHALL compute address increments modulo 2^ADDR_W (wrap-around).
REQ-032 SHALL, when mem_len_i = byte and mem_signed_i = 1, set mem_rdata_o bits [31:8] = bit 7; when unsigned, zero-fill.
REQ-033 SHALL, when mem_len_i = half and mem_signed_i = 1, set mem_rdata_o bits [31:16] = bit 15; when unsigned, zero-fill.
REQ-034 SHALL hold if_rdata_o and mem_rdata_o stable until their next completion.
REQ-035 SHALL, when if_flush_i is high during an IF-owned BUSY, return to IDLE at that edge with no if_done_o, ram_we_o = 0 and no further RAM access.
REQ-036 SHALL ignore if_flush_i during a MEM-owned transaction.
REQ-037 SHALL suppress an IF grant in any cycle where if_flush_i is high.
REQ-038 SHALL ignore request inputs while BUSY; a started transaction is never preempted.

Reset
REQ-039 SHALL, when rst is high at a clock edge, force IDLE, cnt = 0 and fair flag = 0.
REQ-040 SHALL, when rst is high at a clock edge, force ram_we_o = 0, ram_addr_o = 0, ram_wdata_o = 0, both done outputs = 0 and both rdata outputs = 0, including mid-transaction.
REQ-041 SHALL not pulse any done output in the cycle after reset release.

Verification
REQ-042 Fetch: RAM[0x100..0x103] = 13,00,00,00; if_req at 0x100 -> ram_addr_o 0x100..0x103 on consecutive cycles, if_done_o 4 cycles after E0, if_rdata_o = 0x00000013.
REQ-043 Signed loads: RAM[0x20] = 0x80, signed byte load -> mem_rdata_o = 0xFFFFFF80; same address, unsigned half load with RAM[0x21] = 0x01 -> 0x00000180, mem_done_o after 2 cycles.
REQ-044 Store word 0xAABBCCDD at 0x40 -> ram_we_o high 4 cycles with (0x40,DD), (0x41,CC), (0x42,BB), (0x43,AA), then ram_we_o = 0 and mem_done_o pulse.
REQ-045 Contention: if_req and mem_req both raised in the same cycle -> MEM served first, then IF; a mem_req held continuously afterwards -> the IF fetch still completes before the second MEM grant.
REQ-046 Flush and reset: if_flush_i at cnt = 2 of a fetch -> IDLE next cycle with no if_done_o; rst at cnt = 1 of a store -> ram_we_o = 0 and all outputs 0 at the next edge.
REQ-047 Wrap-around: word load at 0xFFFFFFFE -> ram_addr_o sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
